// File: rtl/dma_cfg_axil_slave.sv
// rtl/dma_cfg_axil_slave.sv - AXI4-Lite slave driving NREG DMA config registers via one-hot write strobes
// Optional partial-strobe rejection (SLVERR) when DMA_CFG_WSTRB_CHK_EN is defined.
module dma_cfg_axil_slave #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int NREG   = 8
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      s_awaddr,
    input  logic                   s_awvalid,
    output logic                   s_awready,
    input  logic [DATA_W-1:0]      s_wdata,
    input  logic [DATA_W/8-1:0]    s_wstrb,
    input  logic                   s_wvalid,
    output logic                   s_wready,
    output logic [1:0]             s_bresp,
    output logic                   s_bvalid,
    input  logic                   s_bready,
    input  logic [ADDR_W-1:0]      s_araddr,
    input  logic                   s_arvalid,
    output logic                   s_arready,
    output logic [DATA_W-1:0]      s_rdata,
    output logic [1:0]             s_rresp,
    output logic                   s_rvalid,
    input  logic                   s_rready,
    output logic [NREG-1:0]        reg_en,
    output logic [DATA_W-1:0]      reg_d,
    input  logic [NREG*DATA_W-1:0] reg_q
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t            wstate, wstate_nx;
    rstate_t            rstate, rstate_nx;
    logic               live;
    logic               aw_done, w_done;
    logic               aw_hs, w_hs, ar_hs;
    logic [ADDR_W-1:2]  awaddr_q;
    logic [31:0]        widx, ridx;
    logic [1:0]         exec_resp;
    logic [DATA_W-1:0]  rd_word;
    logic               unused_bits;

`ifdef DMA_CFG_WSTRB_CHK_EN
    logic               strb_ok;
    assign unused_bits = &{1'b0, s_awaddr[1:0], s_araddr[1:0]};
`else
    assign unused_bits = &{1'b0, s_awaddr[1:0], s_araddr[1:0], s_wstrb};
`endif

    always_comb begin
        widx = 32'(awaddr_q);
        if (widx >= 32'(NREG)) exec_resp = RESP_DECERR;
`ifdef DMA_CFG_WSTRB_CHK_EN
        else if (!strb_ok) exec_resp = RESP_SLVERR;
`endif
        else exec_resp = RESP_OKAY;
    end

    // live holds the readies low until the first clock edge after reset release
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wstate <= W_IDLE;
            rstate <= R_IDLE;
            live   <= 1'b0;
        end else begin
            wstate <= wstate_nx;
            rstate <= rstate_nx;
            live   <= 1'b1;
        end
    end

    always_comb begin
        wstate_nx = wstate;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        reg_en    = '0;
        case (wstate)
            W_IDLE: begin
                s_awready = live && !aw_done;
                s_wready  = live && !w_done;
                aw_hs     = s_awvalid && s_awready;
                w_hs      = s_wvalid && s_wready;
                if ((aw_done || aw_hs) && (w_done || w_hs)) wstate_nx = W_EXEC;
            end
            W_EXEC: begin
                for (int k = 0; k < NREG; k++)
                    reg_en[k] = (exec_resp == RESP_OKAY) && (widx == 32'(k));
                wstate_nx = W_RESP;
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) wstate_nx = W_IDLE;
            end
            default: wstate_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            awaddr_q <= '0;
            reg_d    <= '0;
            s_bresp  <= RESP_OKAY;
`ifdef DMA_CFG_WSTRB_CHK_EN
            strb_ok  <= 1'b0;
`endif
        end else begin
            if (aw_hs) begin
                aw_done  <= 1'b1;
                awaddr_q <= s_awaddr[ADDR_W-1:2];
            end
            if (w_hs) begin
                w_done <= 1'b1;
                reg_d  <= s_wdata;
`ifdef DMA_CFG_WSTRB_CHK_EN
                strb_ok <= &s_wstrb;
`endif
            end
            if (wstate == W_EXEC) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                s_bresp <= exec_resp;
            end
            if (wstate == W_RESP && s_bready) s_bresp <= RESP_OKAY;
        end
    end

    always_comb begin
        ridx    = 32'(s_araddr[ADDR_W-1:2]);
        rd_word = '0;
        for (int k = 0; k < NREG; k++)
            if (ridx == 32'(k)) rd_word = reg_q[k*DATA_W +: DATA_W];
    end

    always_comb begin
        rstate_nx = rstate;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        ar_hs     = 1'b0;
        case (rstate)
            R_IDLE: begin
                s_arready = live;
                ar_hs     = s_arvalid && live;
                if (ar_hs) rstate_nx = R_DATA;
            end
            R_DATA: begin
                s_rvalid = 1'b1;
                if (s_rready) rstate_nx = R_IDLE;
            end
            default: rstate_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s_rdata <= '0;
            s_rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            s_rdata <= rd_word;
            s_rresp <= (ridx < 32'(NREG)) ? RESP_OKAY : RESP_DECERR;
        end
    end
endmodule

// File: doc/dma_cfg_axil_slave.md
DMA_CFG_AXIL_SLAVE -- requirements
Module: dma_cfg_axil_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, bus and config word width; even.
REQ-003 SHALL have parameter NREG, default 8, number of downstream config registers.
REQ-004 SHALL have ports:
- clk_in  in  1  the one clock.
- rst  in  1  asynchronous active-high reset.
- s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_W/1/1  AXI4-Lite write address.
- s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  DATA_W/DATA_W/8/1/1  write data.
- s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  write response.
- s_araddr/s_arvalid/s_arready  in/in/out  ADDR_W/1/1  read address.
- s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  DATA_W/2/1/1  read data.
- reg_en  out  NREG  one-hot write strobe, one per config register.
- reg_d  out  DATA_W  write word {mask[DATA_W/2-1:0], value[DATA_W/2-1:0]} passed unchanged from s_wdata.
- reg_q  in  NREG*DATA_W  flattened readback, register k at bits [k*DATA_W +: DATA_W].

Function
REQ-005 SHALL decode word index = addr[ADDR_W-1:2]; addr[1:0] ignored; index >= NREG is out of range.
REQ-006 Write FSM SHALL have states W_IDLE, W_EXEC, W_RESP.
REQ-007 In W_IDLE, s_awready and s_wready SHALL each stay high until its own handshake, then drop; AW and W captured independently, in either order or the same cycle.
REQ-008 SHALL move W_IDLE->W_EXEC on the cycle both AW and W have been captured.
REQ-009 In W_EXEC, for 1 cycle, SHALL drive reg_en[index]=1 and reg_d=captured wdata when in range and accepted; otherwise reg_en=0.
REQ-010 SHALL move W_EXEC->W_RESP unconditionally; s_bvalid=1 in W_RESP, held with s_bresp stable until s_bready; W_RESP->W_IDLE on handshake.
REQ-011 s_bresp SHALL be 2'b00 OKAY for accepted, 2'b11 DECERR for out of range, 2'b10 SLVERR for strobe reject (REQ-019).
REQ-012 Write latency: reg_en pulse 1 cycle after final AW/W handshake; s_bvalid 2 cycles after it.
REQ-013 reg_en SHALL be 0 in all states other than W_EXEC; never more than one bit set.
REQ-014 Read FSM SHALL have states R_IDLE (s_arready=1) and R_DATA (s_rvalid=1).
REQ-015 On AR handshake SHALL register s_rdata=reg_q slice and s_rresp=OKAY, entering R_DATA next cycle; out of range gives s_rdata=0, s_rresp=DECERR.
REQ-016 s_rdata/s_rresp SHALL hold stable while s_rvalid && !s_rready; R_DATA->R_IDLE on handshake.
REQ-017 Read and write FSMs SHALL be independent; read sampling reg_q in the same cycle as W_EXEC returns the pre-write value.

Reset
REQ-018 While rst=1: FSMs in W_IDLE/R_IDLE; all ready, valid and reg_en outputs 0; s_bresp, s_rresp, s_rdata, reg_d 0. Readies rise on first clk_in edge with rst=0. rst mid-transaction abandons it with no response and no reg_en pulse.

Configuration
REQ-019 With DMA_CFG_WSTRB_CHK_EN defined, a write with s_wstrb != all-ones SHALL give no reg_en pulse and bresp=SLVERR; DECERR takes priority. Without it, s_wstrb SHALL be ignored.

Verification
REQ-020 AW addr 0x08 and W data 0x0003_0005 in the same cycle -> reg_en=8'h04 for 1 cycle at +1, reg_d=0x0003_0005, bvalid at +2, bresp=00.
REQ-021 W 0xFFFF_1234 three cycles before AW 0x00 -> wready drops after W, single reg_en=8'h01 pulse 1 cycle after AW, bresp=00.
REQ-022 AW 0x20 (index 8) -> no reg_en pulse, bresp=11; AR 0x20 -> rdata=0, rresp=11.
REQ-023 reg_q[1]=0xA5A5_0001, AR 0x04 with rready low 3 cycles -> rvalid held, rdata=0xA5A5_0001 stable, one handshake.
REQ-024 DMA_CFG_WSTRB_CHK_EN defined, write 0x0C with wstrb=4'b0111 -> reg_en stays 0, bresp=10; without it -> reg_en=8'h08, bresp=00.
REQ-025 rst asserted in W_EXEC -> reg_en drops immediately, no bvalid; after release next write completes normally.
